// File: rtl/mem_responder.sv
// mem_responder: arbitrated single-port word memory answering fetch and data requests.
// Define MEM_RESP_WAIT_EN to insert WAIT_STATES busy cycles per access.
module mem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [3:0]  dmmsel,
  output logic        i_ready,
  output logic        d_ready,
  output logic [31:0] imemload,
  output logic [31:0] dmmload
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d, oor_q, oor_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, imemload_q, imemload_d, dmmload_q, dmmload_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] req_addr, rdata;
  logic d_req, pick_d, accept, enter, unused_lsbs;
`ifdef MEM_RESP_WAIT_EN
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int unused_ws = WAIT_STATES;
`endif
  assign d_req = dmmRen | dmmWen;
  // grant 1 = data port; data wins a tie unless it was served last
  assign pick_d = d_req & ~(imemRen & last_q);
  assign req_addr = pick_d ? dmmaddr : imemaddr;
  assign accept = state_q == IDLE & (imemRen | d_req);
  assign unused_lsbs = ^req_addr[1:0];
  always_comb begin
    grant_d = accept ? pick_d : grant_q;
    addr_d = accept ? req_addr[ADDR_W+1:2] : addr_q;
    oor_d = accept ? |req_addr[31:ADDR_W+2] : oor_q;
    wr_d = accept ? pick_d & dmmWen : wr_q;
    wdata_d = accept ? dmmstore : wdata_q;
    sel_d = accept ? dmmsel : sel_q;
`ifdef MEM_RESP_WAIT_EN
    cnt_d = accept ? CW'(WAIT_STATES - 1) : (state_q == BUSY && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    state_d = accept ? BUSY : state_q == BUSY ? (cnt_q == '0 ? DONE : BUSY) : IDLE;
`else
    state_d = accept ? DONE : IDLE;
`endif
    enter = state_d == DONE && state_q != DONE;
    rdata = oor_d ? '0 : mem[addr_d];
    imemload_d = enter & ~grant_d ? rdata : imemload_q;
    dmmload_d = enter & grant_d & ~wr_d ? rdata : dmmload_q;
    last_d = enter ? grant_d : last_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b0;
      oor_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sel_q <= '0;
      imemload_q <= '0;
      dmmload_q <= '0;
`ifdef MEM_RESP_WAIT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      oor_q <= oor_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sel_q <= sel_d;
      imemload_q <= imemload_d;
      dmmload_q <= dmmload_d;
`ifdef MEM_RESP_WAIT_EN
      cnt_q <= cnt_d;
`endif
    end
  // array is not reset; a write commits only on the edge entering DONE
  always_ff @(posedge CLK)
    if (!RST && enter && wr_d && !oor_d)
      for (int k = 0; k < 4; k++)
        if (sel_d[k]) mem[addr_d][8*k +: 8] <= wdata_d[8*k +: 8];
  assign i_ready = state_q == DONE & ~grant_q;
  assign d_ready = state_q == DONE & grant_q;
  assign imemload = imemload_q;
  assign dmmload = dmmload_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Single-ported word memory that answers the core's instruction-fetch and data-access requests; it is the responder on the far side of the request unit. It arbitrates between the fetch port and the data port, performs one access at a time from an internal array, and returns a one-cycle ready pulse with registered load data. It is used as the memory model in the single-cycle core's top level and in block-level benches.

## Interface
- ADDR_W, 10: word-address width; array holds 2^ADDR_W 32-bit words.
- WAIT_STATES, 2: extra BUSY cycles per access; honoured only when MEM_RESP_WAIT_EN is defined (must be ≥1 then).
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- imemRen  input  1  instruction fetch request (level).
- imemaddr  input  32  fetch byte address.
- dmmRen  input  1  data read request (level).
- dmmWen  input  1  data write request (level).
- dmmaddr  input  32  data byte address.
- dmmstore  input  32  write data.
- dmmsel  input  4  write byte enables; bit k enables byte lane [8k+7:8k].
- i_ready  output  1  one-cycle pulse: fetch complete, imemload valid.
- d_ready  output  1  one-cycle pulse: data access complete, dmmload valid for reads.
- imemload  output  32  registered fetch data; holds until next fetch completes.
- dmmload  output  32  registered read data; holds until next data read completes.

## Operation
- States: IDLE, BUSY, DONE. Registers: state, grant (I or D), latched address/data/sel/write flag, wait counter, last_grant.
- IDLE: if any request high at the edge, accept one and latch its address (and for data: store, sel, write flag). Without macro go to DONE; with macro go to BUSY with counter = WAIT_STATES-1.
- Arbitration when both ports request: data wins, unless last_grant = D, in which case instruction wins (no port starves).
- dmmRen and dmmWen both high: treated as write.
- BUSY: counter decrements each cycle; at 0 go to DONE.
- Edge entering DONE: write commits to array per dmmsel (dmmsel = 0 writes nothing); read word captured into imemload or dmmload; last_grant updated.
- DONE: matching ready high for exactly this cycle; next state IDLE unconditionally.
- Requests are levels; requester holds request, address and data stable until its ready. A request still high in IDLE after its ready is a new access.
- Address: word index = addr[ADDR_W+1:2]; addr[1:0] ignored. Any set bit in addr[31:ADDR_W+2] is out of range: read returns 32'h0, write discarded, ready still pulses.
- Write completes with d_ready; dmmload unchanged on writes.
- Array contents are not reset.

## Timing
- Reset values: i_ready=0, d_ready=0, imemload=0, dmmload=0, state IDLE, last_grant=I, counter 0.
- Reset mid-access: access aborted; a write not yet at the DONE edge never commits.
- Latency from accepting edge to ready-high cycle: 1 cycle without macro, 1+WAIT_STATES with macro.
- Back-to-back throughput: one access per 2 cycles (no macro) or 2+WAIT_STATES (macro), since DONE always returns to IDLE.
- Requests changing while BUSY/DONE have no effect; latched values are used.
- Read after write to same word, in consecutive accesses: returns new data.

## Configuration
- MEM_RESP_WAIT_EN defined: BUSY state and wait counter present; every access takes WAIT_STATES BUSY cycles.
- Undefined: BUSY and counter compiled out; IDLE→DONE directly; WAIT_STATES ignored.

## Test plan
- Reset: assert RST mid-BUSY of write 32'hDEADBEEF to addr 0x10 -> all outputs 0, subsequent read of 0x10 does not return DEADBEEF.
- Write then read: dmmWen, addr 0x20, data 32'h12345678, sel 4'hF; then dmmRen addr 0x20 -> d_ready after 1 cycle (no macro) / 3 cycles (macro, WAIT_STATES=2), dmmload=32'h12345678.
- Byte enables: word 0x40 = 32'hFFFFFFFF, write 32'h000000AB sel 4'b0001 -> read 32'hFFFFFFAB; sel 4'b0000 -> word unchanged.
- Arbitration: imemRen and dmmRen held high continuously -> grants alternate D, I, D, I; ready pulses never overlap.
- Out of range: ADDR_W=10, dmmWen addr 0x0000_1000 -> d_ready pulses, array unchanged; read same addr -> dmmload=0.
- Fetch stream: imemRen held high, addresses 0,4,8 -> i_ready every 2nd cycle (no macro), imemload matches preloaded words, last value held after imemRen drops.
